// File: rtl/puf_pkg.sv
// puf_pkg: shared states, defaults and per-bit repeat count for the RO PUF sequencer (PUF_MAJORITY_EN selects 3 repeats)
package puf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_MEASURE, S_HOLD, S_COMPARE, S_DONE} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SYNC_CYC = 2;
  localparam int N_BITS = 256;
  localparam int SEL_W = 4;
`ifdef PUF_MAJORITY_EN
  localparam int N_REP = 3;
`else
  localparam int N_REP = 1;
`endif
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/puf_phase_timer.sv
// puf_phase_timer: loadable down-counter that flags the last cycle of a phase
module puf_phase_timer #(
  parameter int MAX = 1024,
  localparam int W = MAX > 1 ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);
  logic [W-1:0] r_value;
  // reload with (phase length - 1) on entry, then count down and park at zero
  always_ff @(posedge clk)
    if (reset) r_value <= '0;
    else if (i_load) r_value <= i_value;
    else if (r_value != '0) r_value <= r_value - W'(1);
  assign o_expired = r_value == '0;
endmodule

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: steps 256 RO pair measurements into a response word (PUF_MAJORITY_EN enables 3-way majority vote per bit)
module ro_puf_sequencer
  import puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int WINDOW = DEF_WINDOW,
  parameter int SYNC_CYC = DEF_SYNC_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        challenge,
  input  logic [CNT_W-1:0]  cnt_a,
  input  logic [CNT_W-1:0]  cnt_b,
  output logic [SEL_W-1:0]  ro_sel_a,
  output logic [SEL_W-1:0]  ro_sel_b,
  output logic              ro_en,
  output logic              cnt_clear,
  output logic [N_BITS-1:0] response,
  output logic              response_DV,
  output logic              busy
);
  localparam int TMAX = max3(SETTLE, WINDOW, SYNC_CYC);
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] L_SETTLE = TW'(SETTLE - 1);
  localparam logic [TW-1:0] L_WINDOW = TW'(WINDOW - 1);
  localparam logic [TW-1:0] L_SYNC = TW'(SYNC_CYC - 1);
  state_t r_state, w_next;
  logic [7:0] r_idx, r_chal, r_pair;
  logic [N_BITS-1:0] r_resp;
  logic [TW-1:0] w_load_val;
  logic w_load, w_exp, w_cmp, w_bit, w_bit_done, w_last;
  puf_phase_timer #(.MAX(TMAX)) u_timer (
    .clk(clk), .reset(reset), .i_load(w_load), .i_value(w_load_val), .o_expired(w_exp)
  );
  assign w_cmp = cnt_a > cnt_b;
`ifdef PUF_MAJORITY_EN
  logic [1:0] r_votes, r_rep;
  assign w_bit_done = r_rep == 2'(N_REP - 1);
  assign w_bit = (r_votes + {1'b0, w_cmp}) >= 2'd2;
  // tally wins across the repeats of one pair; cleared once the bit is decided
  always_ff @(posedge clk)
    if (reset) begin
      r_votes <= '0;
      r_rep <= '0;
    end else if (r_state == S_COMPARE) begin
      r_votes <= w_bit_done ? 2'd0 : r_votes + {1'b0, w_cmp};
      r_rep <= w_bit_done ? 2'd0 : r_rep + 2'd1;
    end
`else
  assign w_bit_done = 1'b1;
  assign w_bit = w_cmp;
`endif
  assign w_last = w_bit_done && r_idx == 8'hFF;
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state and phase-timer reload on every timed phase entry
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_load_val = L_SETTLE;
    case (r_state)
      S_IDLE: if (start) begin
        w_next = S_SELECT;
        w_load = 1'b1;
      end
      S_SELECT: if (w_exp) begin
        w_next = S_MEASURE;
        w_load = 1'b1;
        w_load_val = L_WINDOW;
      end
      S_MEASURE: if (w_exp) begin
        w_next = S_HOLD;
        w_load = 1'b1;
        w_load_val = L_SYNC;
      end
      S_HOLD: w_next = w_exp ? S_COMPARE : S_HOLD;
      S_COMPARE: begin
        w_next = w_last ? S_DONE : S_SELECT;
        w_load = !w_last;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // challenge latch, bit index, registered pair select and response shift register
  always_ff @(posedge clk)
    if (reset) begin
      r_idx <= '0;
      r_chal <= '0;
      r_pair <= '0;
      r_resp <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_idx <= '0;
      r_chal <= challenge;
      r_pair <= challenge;
      r_resp <= '0;
    end else if (r_state == S_COMPARE && w_bit_done) begin
      r_resp <= {r_resp[N_BITS-2:0], w_bit};
      if (!w_last) begin
        r_idx <= r_idx + 8'd1;
        r_pair <= (r_idx + 8'd1) ^ r_chal;
      end
    end
  assign ro_sel_a = r_pair[7:4];
  assign ro_sel_b = r_pair[3:0];
  assign ro_en = r_state == S_MEASURE;
  assign cnt_clear = r_state == S_SELECT;
  assign busy = r_state != S_IDLE;
  assign response_DV = r_state == S_DONE;
  assign response = r_resp;
endmodule
